// File: rtl/acc_divider_if.sv
// Start/busy/done handshake bundle between a controller and the
// sequential accumulator divider.
interface acc_divider_if #(
  parameter int DW = 16,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] Dividend;
  logic [VW-1:0] Divisor;
  logic [DW-1:0] Quotient;
  logic [VW-1:0] Remainder;
  logic          busy;
  logic          done;
  logic          div_zero;

  modport master (
    output start, Dividend, Divisor,
    input  Quotient, Remainder, busy, done, div_zero
  );

  modport slave (
    input  start, Dividend, Divisor,
    output Quotient, Remainder, busy, done, div_zero
  );
endinterface

// File: rtl/acc_divider.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, MSB first, with a start/busy/done handshake.
module acc_divider #(
  parameter int DW = 16,
  parameter int VW = 4
) (
  input  logic         clk,
  input  logic         rst,
  acc_divider_if.slave bus
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   p_q, p_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [VW-1:0] divisor_q, divisor_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic          div_zero_q, div_zero_d;

  logic [VW:0]   trial;
  logic          trial_ge;
  logic [VW:0]   p_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      shreg_q    <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      shreg_q    <= shreg_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // shreg shifts dividend bits out at the top while quotient bits enter at the bottom
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    shreg_d    = shreg_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    trial    = {p_q[VW-1:0], shreg_q[DW-1]};
    trial_ge = (trial >= {1'b0, divisor_q});
    p_next   = trial_ge ? (trial - {1'b0, divisor_q}) : trial;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d      = '0;
          p_d        = '0;
          shreg_d    = bus.Dividend;
          divisor_d  = bus.Divisor;
          div_zero_d = 1'b0;
          if (bus.Divisor == '0) begin
            quot_d     = '1;
            rem_d      = '0;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d     = p_next;
        shreg_d = {shreg_q[DW-2:0], trial_ge};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          quot_d  = {shreg_q[DW-2:0], trial_ge};
          rem_d   = p_next[VW-1:0];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Quotient  = quot_q;
    bus.Remainder = rem_q;
    bus.busy      = (state_q == RUN);
    bus.done      = done_q;
    bus.div_zero  = div_zero_q;
  end
endmodule

// File: tb/tb_acc_divider.sv
// Directed-vector bench for acc_divider: results, latency, handshake,
// zero divide, back-to-back starts and asynchronous reset.
module tb_acc_divider;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  acc_divider_if #(.DW(16), .VW(4)) dif ();

  acc_divider #(.DW(16), .VW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start beat; on return we sit 1 time unit after the accept edge.
  task automatic start_op(input logic [15:0] dvd, input logic [3:0] dvs);
    dif.start    = 1'b1;
    dif.Dividend = dvd;
    dif.Divisor  = dvs;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  // Waits (bounded) for done, tallying busy cycles and whether outputs held.
  task automatic wait_done(input bit pulse, output int lat, output int busy_cycles,
                           output bit held);
    logic [15:0] q0;
    logic [3:0]  r0;
    q0 = dif.Quotient;
    r0 = dif.Remainder;
    lat = 0;
    held = 1'b1;
    busy_cycles = dif.busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (pulse && (i == 4 || i == 9)) begin
        dif.start    = 1'b1;
        dif.Dividend = 16'd50000;
        dif.Divisor  = 4'd1;
      end else begin
        dif.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (dif.done) break;
      if (dif.busy) busy_cycles++;
      if (dif.Quotient !== q0 || dif.Remainder !== r0) held = 1'b0;
    end
    dif.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.start = 1'b0;
    dif.Dividend = '0;
    dif.Divisor = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({dif.Quotient, dif.Remainder, dif.busy, dif.done, dif.div_zero} !== 23'd0) begin
      bad++;
      $display("FAIL reset_state got Q=%0d R=%0d busy=%b done=%b dz=%b want all 0",
               dif.Quotient, dif.Remainder, dif.busy, dif.done, dif.div_zero);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    bit held;
    start_op(16'd1000, 4'd7);
    total++;
    if (dif.busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_after_accept got %b want 1", dif.busy);
    end
    wait_done(1'b0, lat, bc, held);
    total++;
    if (lat !== 16) begin bad++; $display("FAIL basic_latency got %0d want 16", lat); end
    total++;
    if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
    total++;
    if (held !== 1'b1) begin bad++; $display("FAIL basic_hold got %b want 1", held); end
    total++;
    if (dif.Quotient !== 16'd142 || dif.Remainder !== 4'd6) begin
      bad++;
      $display("FAIL basic_1000_7 got %0d r%0d want 142 r6", dif.Quotient, dif.Remainder);
    end
    total++;
    if (dif.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got %b want 0", dif.busy); end
    @(posedge clk);
    #1;
    total++;
    if (dif.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got %b want 0", dif.done); end
  endtask

  task automatic test_extremes;
    int lat, bc;
    bit held;
    start_op(16'd65535, 4'd15);
    wait_done(1'b0, lat, bc, held);
    total++;
    if (lat !== 16 || dif.Quotient !== 16'd4369 || dif.Remainder !== 4'd0) begin
      bad++;
      $display("FAIL max_65535_15 got lat=%0d %0d r%0d want lat=16 4369 r0",
               lat, dif.Quotient, dif.Remainder);
    end
    @(posedge clk);
    #1;
    start_op(16'd3, 4'd9);
    wait_done(1'b0, lat, bc, held);
    total++;
    if (lat !== 16 || dif.Quotient !== 16'd0 || dif.Remainder !== 4'd3) begin
      bad++;
      $display("FAIL small_3_9 got lat=%0d %0d r%0d want lat=16 0 r3",
               lat, dif.Quotient, dif.Remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero;
    int lat, bc;
    bit held;
    start_op(16'd5, 4'd0);
    total++;
    if (dif.done !== 1'b1 || dif.div_zero !== 1'b1 || dif.busy !== 1'b0) begin
      bad++;
      $display("FAIL dz_flags got done=%b dz=%b busy=%b want 1 1 0",
               dif.done, dif.div_zero, dif.busy);
    end
    total++;
    if (dif.Quotient !== 16'hFFFF || dif.Remainder !== 4'd0) begin
      bad++;
      $display("FAIL dz_result got %0d r%0d want 65535 r0", dif.Quotient, dif.Remainder);
    end
    @(posedge clk);
    #1;
    total++;
    if (dif.done !== 1'b0 || dif.div_zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_hold got done=%b dz=%b want 0 1", dif.done, dif.div_zero);
    end
    start_op(16'd20, 4'd4);
    total++;
    if (dif.div_zero !== 1'b0 || dif.busy !== 1'b1) begin
      bad++;
      $display("FAIL dz_clear got dz=%b busy=%b want 0 1", dif.div_zero, dif.busy);
    end
    wait_done(1'b0, lat, bc, held);
    total++;
    if (lat !== 16 || dif.Quotient !== 16'd5 || dif.Remainder !== 4'd0 || dif.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL after_dz_20_4 got lat=%0d %0d r%0d dz=%b want lat=16 5 r0 dz=0",
               lat, dif.Quotient, dif.Remainder, dif.div_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    bit held;
    start_op(16'd100, 4'd3);
    wait_done(1'b0, lat, bc, held);
    total++;
    if (lat !== 16 || dif.Quotient !== 16'd33 || dif.Remainder !== 4'd1) begin
      bad++;
      $display("FAIL b2b_100_3 got lat=%0d %0d r%0d want lat=16 33 r1",
               lat, dif.Quotient, dif.Remainder);
    end
    start_op(16'd9, 4'd4);
    total++;
    if (dif.done !== 1'b0 || dif.busy !== 1'b1 || dif.Quotient !== 16'd33) begin
      bad++;
      $display("FAIL b2b_accept got done=%b busy=%b Q=%0d want 0 1 33",
               dif.done, dif.busy, dif.Quotient);
    end
    wait_done(1'b1, lat, bc, held);
    total++;
    if (lat !== 16 || bc !== 16 || held !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ignore_busy got lat=%0d busy=%0d held=%b want 16 16 1", lat, bc, held);
    end
    total++;
    if (dif.Quotient !== 16'd2 || dif.Remainder !== 4'd1) begin
      bad++;
      $display("FAIL b2b_9_4 got %0d r%0d want 2 r1", dif.Quotient, dif.Remainder);
    end
    @(posedge clk);
    #1;
    total++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic test_async_reset;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({dif.Quotient, dif.Remainder, dif.busy, dif.done, dif.div_zero} !== 23'd0) begin
      bad++;
      $display("FAIL async_reset got Q=%0d R=%0d busy=%b done=%b dz=%b want all 0",
               dif.Quotient, dif.Remainder, dif.busy, dif.done, dif.div_zero);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    int lat, bc, done_seen;
    bit held;
    start_op(16'd200, 4'd9);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.Quotient !== 16'd0) begin
      bad++;
      $display("FAIL abort_reset got busy=%b done=%b Q=%0d want 0 0 0",
               dif.busy, dif.done, dif.Quotient);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (dif.done || dif.busy) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done got %0d active cycles want 0", done_seen);
    end
    start_op(16'd225, 4'd15);
    wait_done(1'b0, lat, bc, held);
    total++;
    if (lat !== 16 || dif.Quotient !== 16'd15 || dif.Remainder !== 4'd0) begin
      bad++;
      $display("FAIL abort_then_225_15 got lat=%0d %0d r%0d want lat=16 15 r0",
               lat, dif.Quotient, dif.Remainder);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_async_reset();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
